mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for the MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU one bit per cycle and holds the result in its HI/LO registers.
- Its hi/lo outputs feed the result-select multiplexer in front of register write-back (MFHI/MFLO path).
- Also supports MTHI/MTLO writes.

Parameters:
DATA_WIDTH, 32, operand and HI/LO register width; must be >= 4.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only when busy == 0
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
operand_a  input  DATA_WIDTH  multiplicand / dividend
operand_b  input  DATA_WIDTH  multiplier / divisor
hi_we  input  1  MTHI write strobe
lo_we  input  1  MTLO write strobe
wdata  input  DATA_WIDTH  MTHI/MTLO data
busy  output  1  operation in progress
done  output  1  one-cycle pulse: hi/lo just updated by an operation
div_by_zero  output  1  one-cycle pulse coincident with done; set when a DIV/DIVU had operand_b == 0
hi  output  DATA_WIDTH  HI register (product upper half / remainder)
lo  output  DATA_WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset:
  - Takes effect on the clk edge with rst = 1.
  - Clears busy, done, div_by_zero, hi and lo to 0 and puts the FSM in IDLE.
  - Reset mid-operation abandons the operation; no done pulse follows.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE: on an edge with start = 1, latch op, operand_a and operand_b, then go to CALC. busy = 1 from the next cycle.
  - Latching for signed ops: store the operand magnitudes and record the result sign(s).
  - CALC: exactly DATA_WIDTH cycles, one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, driven by an internal iteration counter.
  - FIX: 1 cycle. Applies sign correction:
    - product negated if the operand signs differ;
    - quotient negated if the signs differ;
    - remainder takes the sign of the dividend.
  - DONE: 1 cycle. hi/lo are loaded on the edge entering DONE; done = 1 and busy = 0 during DONE.
  - DONE returns to IDLE. A start asserted during DONE is accepted, with behaviour identical to IDLE.
- Latency: if start is sampled on edge 0, busy is high for cycles 1..DATA_WIDTH+1 and done is high in cycle DATA_WIDTH+2 (cycle 34 for the default width).
- start while busy = 1 is ignored. The latched operands are unaffected by input changes after acceptance.
- Multiply result: hi = upper DATA_WIDTH bits of the 2*DATA_WIDTH product; lo = lower bits.
- Divide result: lo = quotient truncated toward zero; hi = remainder.
- Divide by zero (operand_b == 0):
  - Same latency as a normal divide.
  - lo = all ones, hi = operand_a unchanged.
  - div_by_zero = 1 with done.
  - Applies to both signed and unsigned divides.
- Signed overflow, DIV of the most-negative value by -1: lo = most-negative value (0x80000000), hi = 0, div_by_zero = 0.
- MTHI/MTLO:
  - When busy = 0 and no start is accepted on that edge: hi_we loads wdata into hi and lo_we loads wdata into lo. Both may be asserted together.
  - Ignored while busy = 1.
  - Ignored on an edge where start is accepted (start wins).
  - An MTHI/MTLO write never produces done.
- hi and lo hold their value at all other times. They are never partially updated during CALC/FIX.

Test Plan:
- Reset, then idle: busy = 0, done = 0, hi = lo = 0x00000000. Apply hi_we = 1, wdata = 0x12345678 -> hi = 0x12345678 next cycle, lo unchanged.
- MULT 0xFFFFFFFF * 0x00000002 -> done in cycle 34: hi = 0xFFFFFFFF, lo = 0xFFFFFFFE. MULTU on the same operands -> hi = 0x00000001, lo = 0xFFFFFFFE.
- DIV -7 (0xFFFFFFF9) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 100 / 7 -> lo = 14, hi = 2. DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIVU 7 / 0 -> done and div_by_zero both high in cycle 34: lo = 0xFFFFFFFF, hi = 0x00000007. The following normal op -> div_by_zero = 0.
- Start a MULT, then pulse start with different operands plus lo_we = 1 at cycle 10 -> both ignored; the original result is delivered. A start asserted during the done cycle -> accepted, and busy rises the next cycle.
- Assert rst at cycle 15 of a DIV -> busy, hi and lo go to 0 on that edge, and no done pulse occurs in the following 40 cycles.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// Also supports direct HI/LO writes (MTHI/MTLO) while idle.
module mult_div_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            div_q;
  logic            neg_res_q;
  logic            neg_a_q;
  logic            dbz_q;
  logic [W-1:0]    opnd_q;
  logic [W-1:0]    acc_hi_q;
  logic [W-1:0]    acc_lo_q;
  logic [W-1:0]    hi_q;
  logic [W-1:0]    lo_q;

  logic            accept;
  logic            signed_op;
  logic            a_neg;
  logic            b_neg;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic [W:0]      mul_sum;
  logic [W:0]      div_trial;
  logic [2*W-1:0]  prod;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quo_fix;
  logic [W-1:0]    rem_fix;
  logic [W-1:0]    fix_hi;
  logic [W-1:0]    fix_lo;

  assign accept = start & ((state_q == StIdle) | (state_q == StDone));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StCalc;
      StCalc: if (cnt_q == CW'(W - 1)) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: state_d = start ? StCalc : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy        = (state_q == StCalc) | (state_q == StFix);
    done        = (state_q == StDone);
    div_by_zero = (state_q == StDone) & dbz_q;
    hi          = hi_q;
    lo          = lo_q;
  end

  // Operand conditioning and per-step / sign-fix arithmetic
  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & operand_a[W-1];
    b_neg     = signed_op & operand_b[W-1];
    mag_a     = a_neg ? -operand_a : operand_a;
    mag_b     = b_neg ? -operand_b : operand_b;

    mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : '0)};
    // No borrow (msb clear) means the divisor fits into the partial remainder.
    div_trial = {acc_hi_q, acc_lo_q[W-1]} - {1'b0, opnd_q};

    prod      = {acc_hi_q, acc_lo_q};
    prod_fix  = neg_res_q ? -prod : prod;
    quo_fix   = dbz_q ? '1 : (neg_res_q ? -acc_lo_q : acc_lo_q);
    // With a zero divisor the remainder path ends up holding |dividend|, restoring operand_a.
    rem_fix   = neg_a_q ? -acc_hi_q : acc_hi_q;

    fix_hi    = div_q ? rem_fix : prod_fix[2*W-1:W];
    fix_lo    = div_q ? quo_fix : prod_fix[W-1:0];
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      dbz_q     <= 1'b0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (accept) begin
        cnt_q     <= '0;
        div_q     <= op[1];
        neg_res_q <= a_neg ^ b_neg;
        neg_a_q   <= a_neg;
        dbz_q     <= op[1] & (operand_b == '0);
        opnd_q    <= op[1] ? mag_b : mag_a;
        acc_hi_q  <= '0;
        acc_lo_q  <= op[1] ? mag_a : mag_b;
      end else if (state_q == StCalc) begin
        cnt_q <= cnt_q + 1'b1;
        if (div_q) begin
          if (!div_trial[W]) begin
            acc_hi_q <= div_trial[W-1:0];
          end else begin
            acc_hi_q <= {acc_hi_q[W-2:0], acc_lo_q[W-1]};
          end
          acc_lo_q <= {acc_lo_q[W-2:0], ~div_trial[W]};
        end else begin
          {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[W-1:1]};
        end
      end

      if (state_q == StFix) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else if (!busy && !accept) begin
        if (hi_we) hi_q <= wdata;
        if (lo_we) lo_q <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed test-plan cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic          hi_we;
  logic          lo_we;
  logic [W-1:0]  wdata;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  mult_div_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wdata(wdata),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .hi(hi),
    .lo(lo)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   ecnt  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model written from the architectural rules with plain arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int cyc);
    exp_t        e;
    longint      p;
    logic [63:0] u;
    int          sa;
    int          sbv;
    e.dbz = 1'b0;
    e.cyc = cyc;
    e.hi  = '0;
    e.lo  = '0;
    case (o)
      2'b00: begin
        p    = longint'($signed(a)) * longint'($signed(b));
        u    = p;
        e.hi = u[63:32];
        e.lo = u[31:0];
      end
      2'b01: begin
        u    = {32'd0, a} * {32'd0, b};
        e.hi = u[63:32];
        e.lo = u[31:0];
      end
      2'b10: begin
        if (b == 0) begin
          e.lo = '1; e.hi = a; e.dbz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = '0;
        end else begin
          sa   = $signed(a);
          sbv  = $signed(b);
          e.lo = sa / sbv;
          e.hi = sa % sbv;
        end
      end
      default: begin
        if (b == 0) begin
          e.lo = '1; e.hi = a; e.dbz = 1'b1;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT signals done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: actual=1 required=0 (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("div_by_zero", div_by_zero, e.dbz);
        check("done_cycle", ecnt, e.cyc);
        check("busy_in_done", busy, 0);
      end
    end
  end

  // Drives one start for one cycle and records the expected result and done edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    sb.push_back(model(o, a, b, ecnt + W + 2));
    @(negedge clk);
    start     = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    op        = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nd;
    int n;
    rst = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;

    // MTHI then combined MTHI/MTLO
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo", lo, 0);
    check("mthi_no_done", done, 0);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0F0F;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthilo_hi", hi, 32'hA5A5_0F0F);
    check("mthilo_lo", lo, 32'hA5A5_0F0F);

    // Directed arithmetic cases
    issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0002); wait_idle();
    issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002); wait_idle();
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002); wait_idle();
    issue(2'b11, 32'd100, 32'd7);               wait_idle();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    issue(2'b11, 32'd7, 32'd0);                 wait_idle();
    issue(2'b10, 32'hFFFF_FFF9, 32'd0);         wait_idle();
    issue(2'b00, 32'd3, 32'd5);                 wait_idle();

    // Start and MTLO while busy are ignored
    issue(2'b00, 32'h0001_2345, 32'hFFFF_0003);
    repeat (8) @(negedge clk);
    start = 1'b1; op = 2'b11; operand_a = 32'd999; operand_b = 32'd4;
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    wait_idle();

    // Start during the done cycle is accepted
    issue(2'b11, 32'd1000, 32'd33);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    check("done_seen", done, 1);
    start = 1'b1; op = 2'b00; operand_a = 32'hFFFF_FF00; operand_b = 32'h0000_0100;
    sb.push_back(model(2'b00, 32'hFFFF_FF00, 32'h0000_0100, ecnt + W + 2));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done_start", busy, 1);
    wait_idle();

    // Reset mid-divide abandons the operation
    issue(2'b11, 32'd100, 32'd7); wait_idle();
    issue(2'b10, 32'h7654_3210, 32'hFFFF_FFF3);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    sb.delete();
    rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("no_done_after_reset", nd, 0);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), rnd_val(), rnd_val());
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
